// File: rtl/icache_pkg.sv
// Shared types and sizing helpers for the instruction-cache line-fill engine.
package icache_pkg;

    localparam int ICACHE_WORD_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } refill_state_t;

    function automatic int words_per_line(input int offset_bits);
        return 2 ** (offset_bits - 2);
    endfunction

endpackage

// File: rtl/instruction_cache_refill_if.sv
// Word-read request/acknowledge bus between the refill engine and instruction memory.
interface instruction_cache_refill_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);

endinterface

// File: rtl/refill_lane_assembler.sv
// Lane-wide register written one 32-bit slot at a time; cleared synchronously on reset.
module refill_lane_assembler #(
    parameter int WORDS  = 16,
    parameter int WORD_W = 32,
    parameter int SLOT_W = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    we,
    input  logic [SLOT_W-1:0]       slot,
    input  logic [WORD_W-1:0]       wdata,
    output logic [WORDS*WORD_W-1:0] lane
);

    logic [WORDS-1:0][WORD_W-1:0] slots_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            slots_q <= '0;
        end else if (we) begin
            slots_q[slot] <= wdata;
        end
    end

    assign lane = slots_q;

endmodule

// File: rtl/instruction_cache_refill.sv
// Line-fill engine: fetches a whole cache line word by word and hands it back as one lane.
// Build option ICACHE_REFILL_WRAP_EN: fetch starts at crit_word and wraps (critical-word-first).
module instruction_cache_refill
    import icache_pkg::*;
#(
    parameter  int bits_for_offset  = 6,
    localparam int single_lane_size = 8 * (2 ** bits_for_offset)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start_transfer,
    input  logic [31-bits_for_offset:0]   line_address,
    input  logic [bits_for_offset-3:0]    crit_word,
    output logic                          data_ready,
    output logic [single_lane_size-1:0]   lane_from_memory,
    instruction_cache_refill_if.master    mem
);

    localparam int WPL = words_per_line(bits_for_offset);
    localparam int WB  = bits_for_offset - 2;
    localparam int CB  = WB + 1;
    localparam int LB  = 32 - bits_for_offset;

    refill_state_t  state, state_d;
    logic [LB-1:0]  line_q, line_d;
    logic [WB-1:0]  start_q, start_d;
    logic [WB-1:0]  word_q, word_d;
    logic [CB-1:0]  count_q, count_d;
    logic           req_q, req_d;
    logic           ready_q, ready_d;
    logic [31:0]    addr_q, addr_d;
    logic [WB-1:0]  start_sel;
    logic           beat;

`ifdef ICACHE_REFILL_WRAP_EN
    assign start_sel = crit_word;
`else
    logic unused_crit;
    assign unused_crit = ^crit_word;
    assign start_sel   = '0;
`endif

    // An ack only counts while a request is outstanding, i.e. in FETCH.
    assign beat = (state == FETCH) && mem.mem_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            line_q  <= '0;
            start_q <= '0;
            word_q  <= '0;
            count_q <= '0;
            req_q   <= 1'b0;
            ready_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state   <= state_d;
            line_q  <= line_d;
            start_q <= start_d;
            word_q  <= word_d;
            count_q <= count_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state;
        line_d  = line_q;
        start_d = start_q;
        word_d  = word_q;
        count_d = count_q;
        req_d   = req_q;
        ready_d = 1'b0;
        addr_d  = addr_q;
        case (state)
            IDLE: begin
                if (start_transfer) begin
                    state_d = FETCH;
                    line_d  = line_address;
                    start_d = start_sel;
                    word_d  = start_sel;
                    count_d = '0;
                    req_d   = 1'b1;
                    addr_d  = {line_address, start_sel, 2'b00};
                end
            end
            FETCH: begin
                if (mem.mem_ack) begin
                    count_d = count_q + 1'b1;
                    word_d  = start_q + count_d[WB-1:0];
                    addr_d  = {line_q, word_d, 2'b00};
                    if (count_q == CB'(WPL - 1)) begin
                        state_d = DONE;
                        req_d   = 1'b0;
                        ready_d = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    refill_lane_assembler #(
        .WORDS (WPL),
        .WORD_W(ICACHE_WORD_BITS),
        .SLOT_W(WB)
    ) u_lane (
        .clock(clock),
        .reset(reset),
        .we   (beat),
        .slot (word_q),
        .wdata(mem.mem_rdata),
        .lane (lane_from_memory)
    );

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign data_ready   = ready_q;

endmodule

// File: tb/tb_instruction_cache_refill.sv
// Self-checking bench: table of refill scenarios against an address-order/lane model, plus reset and stray-ack sequences.
module tb_instruction_cache_refill;
    import icache_pkg::*;

    localparam int BFO  = 6;
    localparam int W    = 16;
    localparam int LB   = 32 - BFO;
    localparam int LANE = 8 * (2 ** BFO);

    logic            clock = 1'b0;
    logic            reset;
    logic            start_transfer;
    logic [LB-1:0]   line_address;
    logic [BFO-3:0]  crit_word;
    logic            data_ready;
    logic [LANE-1:0] lane;

    instruction_cache_refill_if mem_if();

    instruction_cache_refill #(.bits_for_offset(BFO)) dut (
        .clock           (clock),
        .reset           (reset),
        .start_transfer  (start_transfer),
        .line_address    (line_address),
        .crit_word       (crit_word),
        .data_ready      (data_ready),
        .lane_from_memory(lane),
        .mem             (mem_if.master)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: byte address of word w of a line, and the fetch start word.
    function automatic logic [31:0] word_addr(input logic [LB-1:0] line, input int w);
        return (32'(line) << BFO) + 32'(4 * w);
    endfunction

    function automatic int start_of(input logic [BFO-3:0] crit);
`ifdef ICACHE_REFILL_WRAP_EN
        return int'(crit);
`else
        return 0;
`endif
    endfunction

    task automatic check_lane(input string name, input logic [LB-1:0] line, input logic [31:0] key);
        bit ok = 1'b1;
        logic [31:0] act = '0, exp = '0;
        for (int k = 0; k < W; k++) begin
            if (ok && lane[32*k +: 32] !== (word_addr(line, k) ^ key)) begin
                ok  = 1'b0;
                act = lane[32*k +: 32];
                exp = word_addr(line, k) ^ key;
            end
        end
        check(name, ok, act, exp);
    endtask

    // ack_mode: 0 = every cycle, 1 = every third cycle, 2 = random.
    task automatic run_refill(input logic [LB-1:0] line, input logic [BFO-3:0] crit, input int ack_mode,
                              input bit drop, input logic [31:0] key, input int exp_ready);
        int idx = 0, cyc = 0, st;
        bit ack, seq_ok = 1'b1;
        logic [31:0] ea, bad_act = '0, bad_exp = '0;
        st = start_of(crit);
        @(negedge clock);
        start_transfer = 1'b1;
        line_address   = line;
        crit_word      = crit;
        mem_if.mem_ack = 1'b0;
        @(posedge clock);
        while (idx < W && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            ea = word_addr(line, (st + idx) % W);
            if (seq_ok && !(mem_if.mem_req === 1'b1 && mem_if.mem_addr === ea && data_ready === 1'b0)) begin
                seq_ok  = 1'b0;
                bad_act = mem_if.mem_addr;
                bad_exp = ea;
            end
            if (drop && idx == 5) begin
                start_transfer = 1'b0;
                line_address   = LB'($urandom);
                crit_word      = (BFO-2)'($urandom);
            end
            case (ack_mode)
                0:       ack = 1'b1;
                1:       ack = (cyc % 3 == 0);
                default: ack = 1'($urandom_range(0, 1));
            endcase
            mem_if.mem_ack   = ack;
            mem_if.mem_rdata = ack ? (ea ^ key) : $urandom;
            @(posedge clock);
            if (ack) idx++;
        end
        check("addr_seq", seq_ok && idx == W, bad_act, bad_exp);
        @(negedge clock);
        cyc++;
        mem_if.mem_ack = 1'b0;
        check("ready_pulse", data_ready === 1'b1, 32'(data_ready), 32'd1);
        if (exp_ready > 0) check("ready_cycle", cyc == exp_ready, 32'(cyc), 32'(exp_ready));
        start_transfer = 1'b0;
        @(negedge clock);
        check("ready_width", data_ready === 1'b0 && mem_if.mem_req === 1'b0, 32'(data_ready), 32'd0);
        check_lane("lane", line, key);
    endtask

    typedef struct {
        logic [LB-1:0]  line;
        logic [BFO-3:0] crit;
        int             ack_mode;
        bit             drop;
        logic [31:0]    key;
        int             exp_ready;
    } vec_t;

    function automatic vec_t mk(input logic [LB-1:0] line, input logic [BFO-3:0] crit, input int mode,
                                input bit drop, input logic [31:0] key, input int exp_ready);
        vec_t v;
        v.line = line; v.crit = crit; v.ack_mode = mode;
        v.drop = drop; v.key = key;   v.exp_ready = exp_ready;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        logic [LANE-1:0] saved;
        bit quiet;

        vecs[0] = mk(26'h0001234, 4'd0,  0, 1'b0, 32'h0,              W + 1);
        vecs[1] = mk(LB'($urandom), 4'd5, 1, 1'b0, $urandom,          3 * W + 1);
        vecs[2] = mk(26'h0001234, 4'd13, 0, 1'b0, 32'h0,              W + 1);
        vecs[3] = mk(LB'($urandom), 4'd7, 0, 1'b1, $urandom,          W + 1);
        vecs[4] = mk(LB'($urandom), 4'd15, 2, 1'b0, $urandom,         -1);
        vecs[5] = mk(LB'($urandom), 4'd2, 2, 1'b1, $urandom,          -1);

        reset = 1'b1;
        start_transfer = 1'b0;
        line_address = '0;
        crit_word = '0;
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", data_ready === 1'b0, 32'(data_ready), 32'd0);
        check("rst_req", mem_if.mem_req === 1'b0, 32'(mem_if.mem_req), 32'd0);
        check("rst_addr", mem_if.mem_addr === 32'd0, mem_if.mem_addr, 32'd0);
        check("rst_lane", lane === '0, lane[31:0], 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run_refill(vecs[i].line, vecs[i].crit, vecs[i].ack_mode, vecs[i].drop, vecs[i].key, vecs[i].exp_ready);

        // Stray acks while idle must not touch the lane.
        saved = lane;
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (data_ready !== 1'b0 || mem_if.mem_req !== 1'b0) quiet = 1'b0;
            mem_if.mem_ack   = 1'b1;
            mem_if.mem_rdata = $urandom;
        end
        @(negedge clock);
        mem_if.mem_ack = 1'b0;
        check("stray_ack_lane", lane === saved && quiet, lane[31:0], saved[31:0]);

        // Reset in the 5th FETCH cycle aborts the refill and clears the lane.
        @(negedge clock);
        start_transfer = 1'b1;
        line_address   = 26'h2ABCDEF;
        crit_word      = 4'd3;
        @(posedge clock);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            mem_if.mem_ack   = 1'b1;
            mem_if.mem_rdata = $urandom;
            if (c == 5) reset = 1'b1;
            @(posedge clock);
        end
        @(negedge clock);
        check("rst_mid_req", mem_if.mem_req === 1'b0, 32'(mem_if.mem_req), 32'd0);
        check("rst_mid_lane", lane === '0, lane[31:0], 32'd0);
        reset = 1'b0;
        start_transfer = 1'b0;
        mem_if.mem_ack = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (data_ready !== 1'b0) quiet = 1'b0;
        end
        check("rst_mid_no_ready", quiet, 32'(!quiet), 32'd0);
        run_refill(26'h0000FFF, 4'd9, 0, 1'b0, 32'h5A5A0000, W + 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
